// File: rtl/pifo_reg_pkg.sv
// Shared constants and flattened-bus layout helpers for the register PIFO.
// Used by the slot store and the max-reduction tree so both agree on bit positions.
package pifo_reg_pkg;

  localparam int PIFO_REG_WIDTH  = 4;
  localparam int PIFO_IDX_WIDTH  = 2;
  localparam int PIFO_DATA_WIDTH = 8;

  function automatic int slot_lsb(input int k, input int w);
    return k * w;
  endfunction

  function automatic int slot_msb(input int k, input int w);
    return (k + 1) * w - 1;
  endfunction

endpackage

// File: rtl/pifo_free_slot_enc.sv
// Lowest-numbered free slot finder: priority encoder over ~vld.
// Ports: vld (slot occupancy) -> free_idx (lowest free slot), any_free.
module pifo_free_slot_enc
  import pifo_reg_pkg::*;
#(
  parameter int REG_WIDTH = PIFO_REG_WIDTH,
  parameter int IDX_WIDTH = PIFO_IDX_WIDTH
) (
  input  logic [REG_WIDTH-1:0] vld,
  output logic [IDX_WIDTH-1:0] free_idx,
  output logic                 any_free
);

  // Scan high to low so the lowest free slot wins last.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = REG_WIDTH - 1; i >= 0; i--) begin
      if (!vld[i]) begin
        free_idx = IDX_WIDTH'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pifo_reg_store.sv
// Register-file slot store of the register PIFO: insert port writes the lowest free
// slot, remove port pops the tree-selected slot into a registered dequeue output.
// Ports: clk/rst, ins_*, rem_*, deq_*, flattened data_out/idx_out/vld_out, count, rem_err.
module pifo_reg_store
  import pifo_reg_pkg::*;
#(
  parameter int REG_WIDTH  = PIFO_REG_WIDTH,
  parameter int IDX_WIDTH  = PIFO_IDX_WIDTH,
  parameter int DATA_WIDTH = PIFO_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ins_valid,
  input  logic [DATA_WIDTH-1:0]           ins_data,
  output logic                            ins_ready,
  input  logic                            rem_valid,
  input  logic [IDX_WIDTH-1:0]            rem_idx,
  output logic                            deq_valid,
  output logic [DATA_WIDTH-1:0]           deq_data,
  output logic [IDX_WIDTH-1:0]            deq_idx,
  output logic [REG_WIDTH*DATA_WIDTH-1:0] data_out,
  output logic [REG_WIDTH*IDX_WIDTH-1:0]  idx_out,
  output logic [REG_WIDTH-1:0]            vld_out,
  output logic [IDX_WIDTH:0]              count,
  output logic                            rem_err
);

  localparam logic [IDX_WIDTH:0] FULL = (IDX_WIDTH + 1)'(REG_WIDTH);
  localparam logic [IDX_WIDTH:0] ONE  = (IDX_WIDTH + 1)'(1);

  logic [IDX_WIDTH-1:0] free_idx;
  logic                 any_free;
  logic                 ins_fire;
  logic                 rem_hit;
  logic                 rem_miss;

  pifo_free_slot_enc #(
    .REG_WIDTH(REG_WIDTH),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_enc (
    .vld     (vld_out),
    .free_idx(free_idx),
    .any_free(any_free)
  );

  for (genvar k = 0; k < REG_WIDTH; k++) begin : g_idx
    assign idx_out[slot_msb(k, IDX_WIDTH) -: IDX_WIDTH] = IDX_WIDTH'(k);
  end

  // Ready depends only on registered count, never on rem_valid.
  assign ins_ready = (count != FULL);
  assign ins_fire  = ins_valid & ins_ready & any_free;
  assign rem_hit   = rem_valid & vld_out[rem_idx];
  assign rem_miss  = rem_valid & ~vld_out[rem_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_out   <= '0;
      data_out  <= '0;
      count     <= '0;
      deq_valid <= 1'b0;
      deq_data  <= '0;
      deq_idx   <= '0;
      rem_err   <= 1'b0;
    end else begin
      deq_valid <= rem_hit;
      if (rem_hit) begin
        deq_data <= data_out[slot_lsb(int'(rem_idx), DATA_WIDTH) +: DATA_WIDTH];
        deq_idx  <= rem_idx;
        vld_out[rem_idx] <= 1'b0;
      end
      // free_idx comes from the pre-cycle vector, so it never aliases rem_idx.
      if (ins_fire) begin
        data_out[slot_lsb(int'(free_idx), DATA_WIDTH) +: DATA_WIDTH] <= ins_data;
        vld_out[free_idx] <= 1'b1;
      end
      unique case ({ins_fire, rem_hit})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (rem_miss)
        rem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pifo_reg_store.sv
// Self-checking bench for pifo_reg_store: directed vector table, reset-during-remove
// sequence, then randomized traffic against a slot-array reference model.
module tb_pifo_reg_store;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_valid;
  logic [7:0]  ins_data;
  logic        ins_ready;
  logic        rem_valid;
  logic [1:0]  rem_idx;
  logic        deq_valid;
  logic [7:0]  deq_data;
  logic [1:0]  deq_idx;
  logic [31:0] data_out;
  logic [7:0]  idx_out;
  logic [3:0]  vld_out;
  logic [2:0]  count;
  logic        rem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pifo_reg_store dut (
    .clk      (clk),
    .rst      (rst),
    .ins_valid(ins_valid),
    .ins_data (ins_data),
    .ins_ready(ins_ready),
    .rem_valid(rem_valid),
    .rem_idx  (rem_idx),
    .deq_valid(deq_valid),
    .deq_data (deq_data),
    .deq_idx  (deq_idx),
    .data_out (data_out),
    .idx_out  (idx_out),
    .vld_out  (vld_out),
    .count    (count),
    .rem_err  (rem_err)
  );

  typedef struct {
    bit         iv;
    logic [7:0] id;
    bit         rv;
    logic [1:0] ri;
    logic [3:0] vld;
    logic [2:0] cnt;
    bit         rdy;
    bit         dv;
    logic [7:0] dd;
    logic [1:0] di;
    bit         err;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[12];

  // Reference model state
  bit         mv[4];
  logic [7:0] md[4];
  bit         m_dv;
  logic [7:0] m_dd;
  logic [1:0] m_di;
  bit         m_err;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit iv, input logic [7:0] id,
                       input bit rv, input logic [1:0] ri);
    rst       = r;
    ins_valid = iv;
    ins_data  = id;
    rem_valid = rv;
    rem_idx   = ri;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 4; i++) c += mv[i];
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 0;
      md[i] = 8'd0;
    end
    m_dv  = 0;
    m_dd  = 8'd0;
    m_di  = 2'd0;
    m_err = 0;
  endtask

  // Applies one clock edge of the spec's rules to the model.
  task automatic m_step(input bit r, input bit iv, input logic [7:0] id,
                        input bit rv, input logic [1:0] ri);
    bit rdy;
    int free;
    bit hit;
    if (r) begin
      m_reset();
      return;
    end
    rdy  = (m_count() != 4);
    free = -1;
    for (int i = 3; i >= 0; i--) if (!mv[i]) free = i;
    hit  = rv && mv[ri];
    m_dv = hit;
    if (hit) begin
      m_dd = md[ri];
      m_di = ri;
      mv[ri] = 0;
    end
    if (rv && !hit) m_err = 1;
    if (iv && rdy && free >= 0) begin
      md[free] = id;
      mv[free] = 1;
    end
  endtask

  task automatic m_compare();
    logic [3:0] ev;
    for (int i = 0; i < 4; i++) ev[i] = mv[i];
    chk("rnd_vld", {28'd0, vld_out}, {28'd0, ev});
    chk("rnd_count", {29'd0, count}, 32'(m_count()));
    chk("rnd_ready", {31'd0, ins_ready}, {31'd0, m_count() != 4});
    chk("rnd_deq_valid", {31'd0, deq_valid}, {31'd0, m_dv});
    chk("rnd_err", {31'd0, rem_err}, {31'd0, m_err});
    if (m_dv) begin
      chk("rnd_deq_data", {24'd0, deq_data}, {24'd0, m_dd});
      chk("rnd_deq_idx", {30'd0, deq_idx}, {30'd0, m_di});
    end
    for (int k = 0; k < 4; k++)
      if (mv[k]) chk("rnd_slot", {24'd0, data_out[k*8 +: 8]}, {24'd0, md[k]});
  endtask

  initial begin
    vecs[0]  = '{1, 8'd5, 0, 2'd0, 4'b0001, 3'd1, 1, 0, 8'd0, 2'd0, 0, 32'h00000005};
    vecs[1]  = '{1, 8'd9, 0, 2'd0, 4'b0011, 3'd2, 1, 0, 8'd0, 2'd0, 0, 32'h00000905};
    vecs[2]  = '{1, 8'd3, 0, 2'd0, 4'b0111, 3'd3, 1, 0, 8'd0, 2'd0, 0, 32'h00030905};
    vecs[3]  = '{1, 8'd7, 0, 2'd0, 4'b1111, 3'd4, 0, 0, 8'd0, 2'd0, 0, 32'h07030905};
    vecs[4]  = '{1, 8'd2, 0, 2'd0, 4'b1111, 3'd4, 0, 0, 8'd0, 2'd0, 0, 32'h07030905};
    vecs[5]  = '{0, 8'd0, 1, 2'd1, 4'b1101, 3'd3, 1, 1, 8'd9, 2'd1, 0, 32'h07030905};
    vecs[6]  = '{1, 8'd4, 0, 2'd0, 4'b1111, 3'd4, 0, 0, 8'd0, 2'd0, 0, 32'h07030405};
    vecs[7]  = '{0, 8'd0, 1, 2'd1, 4'b1101, 3'd3, 1, 1, 8'd4, 2'd1, 0, 32'h07030405};
    vecs[8]  = '{1, 8'd6, 1, 2'd0, 4'b1110, 3'd3, 1, 1, 8'd5, 2'd0, 0, 32'h07030605};
    vecs[9]  = '{0, 8'd0, 1, 2'd0, 4'b1110, 3'd3, 1, 0, 8'd0, 2'd0, 1, 32'h07030605};
    vecs[10] = '{0, 8'd0, 0, 2'd0, 4'b1110, 3'd3, 1, 0, 8'd0, 2'd0, 1, 32'h07030605};
    vecs[11] = '{1, 8'd8, 1, 2'd2, 4'b1011, 3'd3, 1, 1, 8'd3, 2'd2, 1, 32'h07030608};

    drive(1, 0, 8'd0, 0, 2'd0);
    tick();
    tick();
    chk("reset_vld", {28'd0, vld_out}, 32'd0);
    chk("reset_count", {29'd0, count}, 32'd0);
    chk("reset_data", data_out, 32'd0);
    chk("reset_ready", {31'd0, ins_ready}, 32'd1);
    chk("reset_deq", {31'd0, deq_valid}, 32'd0);
    chk("reset_err", {31'd0, rem_err}, 32'd0);
    chk("idx_out", {24'd0, idx_out}, 32'h000000e4);

    for (int i = 0; i < 12; i++) begin
      drive(0, vecs[i].iv, vecs[i].id, vecs[i].rv, vecs[i].ri);
      tick();
      chk("vec_vld", {28'd0, vld_out}, {28'd0, vecs[i].vld});
      chk("vec_count", {29'd0, count}, {29'd0, vecs[i].cnt});
      chk("vec_ready", {31'd0, ins_ready}, {31'd0, vecs[i].rdy});
      chk("vec_deq_valid", {31'd0, deq_valid}, {31'd0, vecs[i].dv});
      chk("vec_err", {31'd0, rem_err}, {31'd0, vecs[i].err});
      chk("vec_data", data_out, vecs[i].data);
      if (vecs[i].dv) begin
        chk("vec_deq_data", {24'd0, deq_data}, {24'd0, vecs[i].dd});
        chk("vec_deq_idx", {30'd0, deq_idx}, {30'd0, vecs[i].di});
      end
    end

    // Reset coinciding with a valid remove: entries dropped, no dequeue pulse.
    drive(1, 1, 8'd1, 1, 2'd0);
    tick();
    chk("rstrem_deq", {31'd0, deq_valid}, 32'd0);
    chk("rstrem_vld", {28'd0, vld_out}, 32'd0);
    chk("rstrem_count", {29'd0, count}, 32'd0);
    chk("rstrem_err", {31'd0, rem_err}, 32'd0);
    chk("rstrem_data", data_out, 32'd0);
    chk("rstrem_ready", {31'd0, ins_ready}, 32'd1);
    chk("rstrem_deq_data", {24'd0, deq_data}, 32'd0);

    m_reset();
    for (int n = 0; n < 600; n++) begin
      bit r, iv, rv;
      logic [7:0] id;
      logic [1:0] ri;
      r  = ($urandom_range(0, 99) < 2);
      iv = ($urandom_range(0, 99) < 55);
      rv = ($urandom_range(0, 99) < 40);
      id = 8'($urandom);
      ri = 2'($urandom);
      drive(r, iv, id, rv, ri);
      m_step(r, iv, id, rv, ri);
      tick();
      m_compare();
    end

    drive(0, 0, 8'd0, 0, 2'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pifo_reg_store.md
Name: pifo_reg_store

Overview:
- Register-file storage side of the register-based PIFO: holds up to REG_WIDTH ranked entries and writes new ranks into free slots.
- Presents all slots as flattened data/idx/valid buses, which feed the pairwise max-reduction tree.
- Accepts a remove request carrying the winning slot index returned by the tree, and pops that entry with a registered dequeue output.

Parameters:
- REG_WIDTH, 4, number of slots; power of two, ≥2.
- IDX_WIDTH, 2, slot index width; equals log2(REG_WIDTH).
- DATA_WIDTH, 8, rank width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- ins_valid  in  1  insert request.
- ins_data  in  DATA_WIDTH  rank to insert.
- ins_ready  out  1  store can accept an insert this cycle.
- rem_valid  in  1  remove request.
- rem_idx  in  IDX_WIDTH  slot to remove (max-tree winner).
- deq_valid  out  1  one-cycle pulse: dequeued entry valid.
- deq_data  out  DATA_WIDTH  rank of dequeued entry.
- deq_idx  out  IDX_WIDTH  slot it came from.
- data_out  out  REG_WIDTH*DATA_WIDTH  slot k occupies bits [(k+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- idx_out  out  REG_WIDTH*IDX_WIDTH  slot k carries constant k.
- vld_out  out  REG_WIDTH  bit k set when slot k is occupied.
- count  out  IDX_WIDTH+1  number of occupied slots.
- rem_err  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, active-high):
  - vld_out=0, data_out=0, count=0.
  - deq_valid=0, deq_data=0, deq_idx=0, rem_err=0.
  - ins_ready=1 after reset.
  - rst mid-operation discards all entries on that edge; no deq_valid is produced for a remove presented in the reset cycle.
- Storage outputs:
  - data_out, vld_out and count are registered and reflect the state after the last edge.
  - idx_out is a constant wiring of slot numbers.
- Insert handshake (ins_fire = ins_valid & ins_ready):
  - ins_ready = (count != REG_WIDTH), registered-state based with no combinational path from rem_valid.
  - On ins_fire, ins_data is written to the lowest-numbered free slot as seen at the start of the cycle, and that vld bit is set.
  - The entry is visible on the buses the next cycle (latency 1).
  - ins_valid while ins_ready=0 is ignored, with no state change; the source holds its request.
- Remove (rem_fire = rem_valid):
  - Remove is accepted unconditionally.
  - If vld_out[rem_idx]=1:
    - next cycle deq_valid=1, deq_data=stored rank, deq_idx=rem_idx;
    - vld bit cleared;
    - slot data retains its old value (don't-care while invalid).
  - If vld_out[rem_idx]=0: no state change, deq_valid=0 next cycle, rem_err set and held until rst.
  - deq_valid is a single-cycle pulse per accepted remove.
- Simultaneous insert and remove in the same cycle:
  - Both are applied.
  - The free-slot choice uses the pre-cycle vld vector, so a slot being freed is never the insert target that cycle.
  - count unchanged when both succeed; count +1 insert only; −1 valid remove only.
  - When full, ins_ready=0, so the insert waits one cycle even if a remove occurs.
- Arithmetic:
  - count is an unsigned IDX_WIDTH+1 bit value and never wraps.
  - 0 ≤ count ≤ REG_WIDTH is guaranteed by ins_ready gating and by ignoring invalid removes.
- There is no FSM beyond per-slot valid bits; the store is a pure register file with two independent ports.

Decomposition:
- Shared package pifo_reg_pkg:
  - default REG_WIDTH/IDX_WIDTH/DATA_WIDTH constants;
  - slot-offset helper functions for the flattened bus layout, so this block and the reduction tree agree on bit positions.
- One sub-module, pifo_free_slot_enc:
  - combinational lowest-set-bit priority encoder over ~vld_out;
  - outputs free_idx (IDX_WIDTH) and any_free.
- Register file and counter stay in the top module.

Test Plan:
- Reset then insert ranks 5, 9, 3, 7 on consecutive cycles:
  - slots 0..3 hold 5, 9, 3, 7 (vld_out=4'b1111, count=4);
  - ins_ready=0 after the fourth insert.
- Full store, ins_valid=1 with data 2 -> ignored; contents unchanged, count=4.
- Full store, rem_idx=1 -> next cycle deq_valid=1, deq_data=9, deq_idx=1, vld_out=4'b1101, count=3, ins_ready=1. Then insert 4 -> lands in slot 1.
- vld_out=4'b1101, same cycle insert 6 and remove idx 0:
  - slot 0 cleared;
  - 6 written to slot 1 (lowest free pre-cycle);
  - vld_out=4'b1110, count=3;
  - deq_data=5.
- Remove idx 2 when slot 2 is empty -> no deq_valid, state unchanged, rem_err=1 and stays 1 until rst.
- rst asserted in the cycle of a valid remove -> all outputs return to reset values the next cycle; no deq_valid pulse.
